// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, PAT_W-bit pattern MSB-first, rep_cnt repetitions
//
// Optional feature macro: SEQ_PATTERN_TX_GAP_EN
//   defined   : one idle (GAP) cycle with busy=1 between repetitions
//   undefined : repetitions are sent back-to-back
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      burst request, sampled only in IDLE
//   rep_cnt    number of pattern repetitions, sampled with start
//   abort      terminate burst at the next edge
//   busy       burst in progress
//   data_out   serial bit, 0 when data_valid=0
//   data_valid data_out carries a pattern bit
//   done       one-cycle pulse on the final bit of a completed burst

module seq_pattern_tx #(
  parameter int               PAT_W = 3,
  parameter logic [PAT_W-1:0] PAT   = 3'b101,
  parameter int               CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             busy,
  output logic             data_out,
  output logic             data_valid,
  output logic             done
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef SEQ_PATTERN_TX_GAP_EN
    GAP   = 2'd2,
`endif
    SHIFT = 2'd1
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;
  logic [CNT_W-1:0] reps_left, reps_n;
  logic             busy_n, valid_n, data_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      reps_left  <= '0;
      busy       <= 1'b0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      reps_left  <= reps_n;
      busy       <= busy_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    reps_n    = reps_left;
    case (state)
      IDLE: begin
        if (start && !abort && (rep_cnt != '0)) begin
          state_n   = SHIFT;
          bit_idx_n = LAST_IDX;
          reps_n    = rep_cnt;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n   = IDLE;
          bit_idx_n = '0;
          reps_n    = '0;
        end else if (bit_idx != '0) begin
          bit_idx_n = bit_idx - IDX_W'(1);
        end else if (reps_left != ONE_REP) begin
          // reps_left counts the repetition in flight, so it is decremented
          // when moving on to the next one and never reaches 0 in SHIFT.
          reps_n = reps_left - ONE_REP;
`ifdef SEQ_PATTERN_TX_GAP_EN
          state_n = GAP;
`else
          bit_idx_n = LAST_IDX;
`endif
        end else begin
          state_n = IDLE;
          reps_n  = '0;
        end
      end
`ifdef SEQ_PATTERN_TX_GAP_EN
      GAP: begin
        if (abort) begin
          state_n   = IDLE;
          bit_idx_n = '0;
          reps_n    = '0;
        end else begin
          state_n   = SHIFT;
          bit_idx_n = LAST_IDX;
        end
      end
`endif
      default: begin
        state_n   = IDLE;
        bit_idx_n = '0;
        reps_n    = '0;
      end
    endcase

    // Outputs are decoded from the next-state values so they can be
    // registered without adding a cycle of latency.
    busy_n  = (state_n != IDLE);
    valid_n = (state_n == SHIFT);
    data_n  = valid_n & PAT[bit_idx_n];
    done_n  = valid_n && (bit_idx_n == '0) && (reps_n == ONE_REP);
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard testbench for seq_pattern_tx

module tb_seq_pattern_tx;

  localparam int          PAT_W = 3;
  localparam logic [2:0]  PAT   = 3'b101;
  localparam int          CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] rep_cnt;
  logic             abort;
  logic             busy;
  logic             data_out;
  logic             data_valid;
  logic             done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic busy;
    logic valid;
    logic data;
    logic done;
    logic last;
  } exp_t;

  exp_t exp_q[$];

  seq_pattern_tx #(.PAT_W(PAT_W), .PAT(PAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rep_cnt    (rep_cnt),
    .abort      (abort),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Overlapping Moore "101" detector fed by the serial link.
  typedef enum logic [1:0] {D0, D1, D10, D101} det_t;
  det_t det_state = D0;
  logic det;
  assign det = (det_state == D101);

  always_ff @(posedge clk) begin
    if (!data_valid) det_state <= D0;
    else begin
      case (det_state)
        D0:      det_state <= data_out ? D1   : D0;
        D1:      det_state <= data_out ? D1   : D10;
        D10:     det_state <= data_out ? D101 : D0;
        default: det_state <= data_out ? D1   : D10;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Pushes the first ncyc cycles of an n-repetition burst.
  function automatic void push_burst(input int n, input int ncyc);
    int c = 0;
    for (int r = 0; r < n; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        if (c < ncyc) exp_q.push_back('{1'b1, 1'b1, PAT[b], (r == n - 1) && (b == 0), (b == 0)});
        c++;
      end
`ifdef SEQ_PATTERN_TX_GAP_EN
      if (r != n - 1) begin
        if (c < ncyc) exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        c++;
      end
`endif
    end
  endfunction

  // Monitor: any non-idle output cycle consumes one scoreboard entry.
  int   det_cnt   = 0;
  logic prev_last = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic cur_last;
    cur_last = 1'b0;
    if (det || prev_last) begin
      check("det_align", det, prev_last);
      if (det) det_cnt++;
    end
    if (busy || data_valid || data_out || done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {busy, data_valid, data_out, done}, 4'b0000);
      end else begin
        e = exp_q.pop_front();
        check("out_vec", {busy, data_valid, data_out, done}, {e.busy, e.valid, e.data, e.done});
        cur_last = e.last;
      end
    end
    prev_last = cur_last;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n);
    start   = 1'b1;
    rep_cnt = CNT_W'(n);
    step();
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 300 && (busy || exp_q.size() != 0); i++) step();
    check({name, "_drained"}, (busy || exp_q.size() != 0), 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rep_cnt = '0; abort = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_data", data_out, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    // Single repetition: 1,0,1 with done on the third bit.
    push_burst(1, 1000);
    issue(1);
    check("rep1_latency", {busy, data_valid, data_out}, 3'b111);
    wait_idle("rep1");

    // Three repetitions.
    push_burst(3, 1000);
    issue(3);
    wait_idle("rep3");

    // rep_cnt=0 is ignored; monitor flags any activity.
    issue(0);
    repeat (10) step();
    check("rep0_busy", busy, 1'b0);

    // start held high: second burst accepted after a single idle cycle.
    push_burst(2, 1000);
    push_burst(2, 1000);
    start = 1'b1; rep_cnt = 4'd2;
    step();
    for (int i = 0; i < 50 && busy; i++) step();
    check("held_idle", busy, 1'b0);
    step();
    check("held_restart", busy, 1'b1);
    start = 1'b0;
    wait_idle("held");

    // Abort after the fourth bit.
    push_burst(2, 4);
    issue(2);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_out", {busy, data_valid, data_out, done}, 4'b0000);
    wait_idle("abort");

    // abort together with start in IDLE.
    start = 1'b1; abort = 1'b1; rep_cnt = 4'd3;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    check("abort_start_busy", busy, 1'b0);

    // Reset mid-burst at cycle 20, then a clean single burst.
    push_burst(15, 20);
    issue(15);
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out", {busy, data_valid, data_out, done}, 4'b0000);
    check("midrst_q", exp_q.size(), 0);
    push_burst(1, 1000);
    issue(1);
    wait_idle("post_rst");

    // Loopback into the detector: one pulse per pattern.
    det_cnt = 0;
    push_burst(4, 1000);
    issue(4);
    wait_idle("loop");
    repeat (2) step();
    check("det_count", det_cnt, 4);

    check("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter; the source side of the team's serial sequence-detector blocks. On a start request it shifts out a fixed PAT_W-bit pattern MSB-first, one bit per clock, repeated rep_cnt times back-to-back. It drives detector-under-test inputs and bit-level loopback links, with a valid qualifier and an end-of-burst pulse.

Parameters:
PAT_W, 3, pattern length in bits (legal range 2..16)
PAT, 3'b101, pattern value; bit PAT_W-1 is sent first
CNT_W, 4, width of repetition count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  burst request; sampled only when idle
rep_cnt  input  CNT_W  number of pattern repetitions; sampled with start
abort  input  1  terminate burst immediately
busy  output  1  burst in progress
data_out  output  1  serial bit
data_valid  output  1  data_out carries a pattern bit this cycle
done  output  1  one-cycle pulse on the final bit of a completed burst

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- All outputs are registered. At reset: busy=0, data_out=0, data_valid=0, done=0, FSM=IDLE, counters=0.
- FSM states:
  - IDLE: outputs 0.
  - SHIFT: data_valid=1, data_out=PAT[bit_idx].
  - GAP: exists only with the optional feature.
- IDLE->SHIFT: at an edge where start=1, abort=0 and rep_cnt!=0.
  - rep_cnt is latched into reps_left.
  - bit_idx is set to PAT_W-1.
  - First bit is visible in the cycle after that edge (latency 1).
- start with rep_cnt=0: ignored, FSM stays IDLE, no outputs change.
- SHIFT: bit_idx decrements each cycle. When bit_idx=0:
  - If reps_left>1: decrement reps_left, reload bit_idx=PAT_W-1, stay in SHIFT. Patterns are back-to-back with no idle bit.
  - If reps_left=1: this cycle has done=1. The next edge goes to IDLE.
- busy=1 in every SHIFT/GAP cycle, including the final-bit cycle. busy=0 in IDLE.
- start while busy=1 is ignored; it is not queued.
- Back-to-back bursts: the earliest accepted start is at the edge ending the first IDLE cycle, so there is at least one idle cycle between bursts.
- abort:
  - Sampled at every edge. If abort=1 while in SHIFT/GAP, the next state is IDLE.
  - All outputs are 0 in the following cycle. done is not asserted for an aborted burst.
  - abort and start together in IDLE: abort wins and start is ignored.
- rst: has priority over everything. Mid-burst reset returns to IDLE at that edge, with no done.
- Counter widths:
  - bit_idx is ceil(log2(PAT_W)) bits.
  - reps_left is CNT_W bits and never wraps; maximum burst is (2^CNT_W-1)*PAT_W bits.
- data_out is 0 whenever data_valid=0.

Optional Feature:
SEQ_PATTERN_TX_GAP_EN
- Defined:
  - After every non-final repetition, FSM enters GAP for exactly one cycle with data_valid=0, data_out=0, busy=1, then returns to SHIFT with bit_idx=PAT_W-1.
  - No GAP after the final repetition.
  - abort in GAP behaves as in SHIFT.
  - Burst length is rep_cnt*PAT_W + (rep_cnt-1) cycles.
- Not defined: GAP state and its logic are absent, and repetitions are contiguous.

Test Plan:
- Reset then start=1, rep_cnt=1 (PAT=101) -> cycles 1..3 after accept: data_out=1,0,1; data_valid=1,1,1; done=0,0,1; busy falls in cycle 4.
- start=1, rep_cnt=3 -> 9 contiguous valid bits 101101101, done only on the 9th. With SEQ_PATTERN_TX_GAP_EN: 101 x 101 x 101 over 11 cycles, data_valid=0 at cycles 4 and 8.
- start=1 with rep_cnt=0 -> busy, data_valid and done stay 0 for 10 cycles. start held high during a rep_cnt=2 burst -> exactly 6 bits, then a new burst accepted one cycle after busy falls.
- rep_cnt=2, abort=1 at the edge after bit 4 is driven -> data_valid=0 and busy=0 from cycle 5, done never asserted. abort+start together in IDLE -> no burst.
- rep_cnt=15, rst=1 mid-burst at bit 20 -> all outputs 0 the next cycle. A subsequent start with rep_cnt=1 produces a clean 101 with done.
- Loopback into an overlapping Moore 101 detector, rep_cnt=4 -> exactly 4 detector pulses, each 1 cycle after a pattern's final bit.
